// File: rtl/glitch_filter_pkg.sv
// Shared definitions for the y_glitch_filter block.
//   gf_state_e            : debounce FSM state encoding
//   StableCyclesDefault   : default number of stable samples to accept a level change
//   CntWDefault           : default width of the event counters
//   state_is_high()       : filtered level implied by an FSM state
package glitch_filter_pkg;

  typedef enum logic [1:0] {
    StLow      = 2'd0,
    StRisePend = 2'd1,
    StHigh     = 2'd2,
    StFallPend = 2'd3
  } gf_state_e;

  localparam int unsigned StableCyclesDefault = 4;
  localparam int unsigned CntWDefault         = 8;

  // A pending fall still reports high until the fall is accepted.
  function automatic logic state_is_high(gf_state_e s);
    return (s == StHigh) || (s == StFallPend);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
//   clk : sampling clock
//   rst : synchronous active-high reset, clears both stages to 0
//   d   : asynchronous input
//   q   : synchronized output (second stage)
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/y_glitch_filter.sv
// Glitch filter / debouncer for the asynchronous output of an upstream logic stage.
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   y_in       : asynchronous, possibly glitchy input
//   clr        : synchronous clear of rise_cnt and glitch_cnt
//   y_f        : filtered level, registered
//   rise/fall  : one-cycle pulses when y_f goes 0->1 / 1->0
//   rise_cnt   : saturating count of accepted rising edges
//   glitch_cnt : saturating count of rejected pulses
module y_glitch_filter
  import glitch_filter_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = StableCyclesDefault,
  parameter int unsigned CNT_W         = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_in,
  input  logic             clr,
  output logic             y_f,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] glitch_cnt
);

  localparam logic [3:0]       StabLast = 4'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic s2;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (y_in),
    .q   (s2)
  );

  gf_state_e        state_q, state_d;
  logic [3:0]       stab_q, stab_d;
  logic             y_f_q, y_f_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;
  logic             accept_rise, accept_fall, reject;

  always_comb begin
    state_d     = state_q;
    stab_d      = stab_q;
    accept_rise = 1'b0;
    accept_fall = 1'b0;
    reject      = 1'b0;
    unique case (state_q)
      StLow: begin
        if (s2) begin
          state_d = StRisePend;
          stab_d  = 4'd1;
        end
      end
      StRisePend: begin
        if (!s2) begin
          state_d = StLow;
          stab_d  = 4'd0;
          reject  = 1'b1;
        end else if (stab_q == StabLast) begin
          state_d     = StHigh;
          stab_d      = 4'd0;
          accept_rise = 1'b1;
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end
      StHigh: begin
        if (!s2) begin
          state_d = StFallPend;
          stab_d  = 4'd1;
        end
      end
      StFallPend: begin
        if (s2) begin
          state_d = StHigh;
          stab_d  = 4'd0;
          reject  = 1'b1;
        end else if (stab_q == StabLast) begin
          state_d     = StLow;
          stab_d      = 4'd0;
          accept_fall = 1'b1;
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end
      default: begin
        state_d = StLow;
        stab_d  = 4'd0;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    y_f_d  = state_is_high(state_d);
    rise_d = accept_rise;
    fall_d = accept_fall;

    // Counters step on the same edge as the pulse they count; clr wins.
    rise_cnt_d = rise_cnt_q;
    if (clr) begin
      rise_cnt_d = '0;
    end else if (accept_rise && (rise_cnt_q != CntMax)) begin
      rise_cnt_d = rise_cnt_q + CntOne;
    end

    glitch_cnt_d = glitch_cnt_q;
    if (clr) begin
      glitch_cnt_d = '0;
    end else if (reject && (glitch_cnt_q != CntMax)) begin
      glitch_cnt_d = glitch_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StLow;
      stab_q       <= 4'd0;
      y_f_q        <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      rise_cnt_q   <= '0;
      glitch_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      stab_q       <= stab_d;
      y_f_q        <= y_f_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      rise_cnt_q   <= rise_cnt_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign y_f        = y_f_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign rise_cnt   = rise_cnt_q;
  assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_y_glitch_filter.sv
// Self-checking bench for y_glitch_filter (STABLE_CYCLES=4, CNT_W=8).
module tb_y_glitch_filter;

  localparam int unsigned Stable = 4;
  localparam int unsigned CntW   = 8;
  localparam int          CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            clr = 1'b0;
  logic            y_in = 1'b0;
  logic            y_f, rise, fall;
  logic [CntW-1:0] rise_cnt, glitch_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a 2-sample delay line followed by a run-length rule.
  // A run of Stable samples opposite to the filtered level flips it;
  // a shorter opposite run ended by a matching sample is a glitch.
  int m_s1, m_s2, m_yf, m_run, m_rise, m_fall, m_rcnt, m_gcnt;

  y_glitch_filter #(
    .STABLE_CYCLES (Stable),
    .CNT_W         (CntW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .y_in       (y_in),
    .clr        (clr),
    .y_f        (y_f),
    .rise       (rise),
    .fall       (fall),
    .rise_cnt   (rise_cnt),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  // Drive one edge with the given inputs, advance the model, settle 1 time unit.
  task automatic tick(input logic r, input logic c, input logic y);
    bit inc_r, inc_g;
    rst  = r;
    clr  = c;
    y_in = y;
    @(posedge clk);
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_yf = 0; m_run = 0;
      m_rise = 0; m_fall = 0; m_rcnt = 0; m_gcnt = 0;
    end else begin
      inc_r = 0;
      inc_g = 0;
      m_rise = 0;
      m_fall = 0;
      if (m_s2 != m_yf) begin
        m_run++;
        if (m_run == Stable) begin
          m_yf  = m_s2;
          m_run = 0;
          if (m_yf == 1) begin
            m_rise = 1;
            inc_r  = 1;
          end else begin
            m_fall = 1;
          end
        end
      end else if (m_run > 0) begin
        m_run = 0;
        inc_g = 1;
      end
      if (c) begin
        m_rcnt = 0;
        m_gcnt = 0;
      end else begin
        if (inc_r && m_rcnt < CntMax) m_rcnt++;
        if (inc_g && m_gcnt < CntMax) m_gcnt++;
      end
      m_s2 = m_s1;
      m_s1 = int'(y);
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    n_total++;
    if ({y_f, rise, fall, rise_cnt, glitch_cnt} !== '0) begin
      $display("FAIL reset: got y_f=%b rise=%b fall=%b rise_cnt=%0d glitch_cnt=%0d, want all 0",
               y_f, rise, fall, rise_cnt, glitch_cnt);
    end else n_pass++;
  endtask

  task automatic test_rise_latency();
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int e = 0; e <= 9; e++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (e == 4) begin
        n_total++;
        if (y_f !== 1'b0) $display("FAIL latency_early: y_f=%b after edge 4, want 0", y_f);
        else n_pass++;
      end
      if (e == 5) begin
        n_total++;
        if ({y_f, rise} !== 2'b11)
          $display("FAIL latency_edge5: y_f=%b rise=%b, want 1 1", y_f, rise);
        else n_pass++;
      end
      if (e == 6) begin
        n_total++;
        if (rise !== 1'b0) $display("FAIL rise_one_cycle: rise=%b after edge 6, want 0", rise);
        else n_pass++;
      end
    end
    n_total++;
    if (rise_cnt !== 8'd1) $display("FAIL rise_cnt_single: got %0d want 1", rise_cnt);
    else n_pass++;
  endtask

  task automatic test_glitch();
    bit saw_rise = 0;
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    saw_rise |= rise;
    tick(1'b0, 1'b0, 1'b1);
    saw_rise |= rise;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      saw_rise |= rise;
    end
    n_total++;
    if ({saw_rise, y_f} !== 2'b00 || glitch_cnt !== 8'd1)
      $display("FAIL glitch_reject: rise_seen=%b y_f=%b glitch_cnt=%0d, want 0 0 1",
               saw_rise, y_f, glitch_cnt);
    else n_pass++;
  endtask

  task automatic test_short_pulse();
    bit saw_rise = 0;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      // Pulse entirely between two edges: never sampled.
      #2 y_in = 1'b1;
      #2 y_in = 1'b0;
      tick(1'b0, 1'b0, 1'b0);
      saw_rise |= rise;
    end
    n_total++;
    if ({saw_rise, y_f} !== 2'b00 || rise_cnt !== 8'd0)
      $display("FAIL short_pulse: rise_seen=%b y_f=%b rise_cnt=%0d, want 0 0 0",
               saw_rise, y_f, rise_cnt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int falls = 0;
    tick(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 260; p++) begin
      for (int i = 0; i < 8; i++) begin
        tick(1'b0, 1'b0, 1'b1);
        falls += int'(fall);
      end
      for (int i = 0; i < 8; i++) begin
        tick(1'b0, 1'b0, 1'b0);
        falls += int'(fall);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      falls += int'(fall);
    end
    n_total++;
    if (rise_cnt !== 8'd255) $display("FAIL rise_cnt_saturate: got %0d want 255", rise_cnt);
    else n_pass++;
    n_total++;
    if (falls != 260) $display("FAIL fall_pulse_count: got %0d want 260", falls);
    else n_pass++;
  endtask

  task automatic test_clr_coincide();
    tick(1'b1, 1'b0, 1'b0);
    for (int e = 0; e <= 4; e++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    n_total++;
    if ({rise, y_f} !== 2'b11 || rise_cnt !== 8'd0)
      $display("FAIL clr_wins: rise=%b y_f=%b rise_cnt=%0d, want 1 1 0", rise, y_f, rise_cnt);
    else n_pass++;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    n_total++;
    if (rise_cnt !== 8'd0) $display("FAIL clr_hold: rise_cnt=%0d want 0", rise_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_mid_pend();
    tick(1'b1, 1'b0, 1'b0);
    for (int e = 0; e <= 3; e++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    n_total++;
    if ({y_f, rise, fall, rise_cnt, glitch_cnt} !== '0)
      $display("FAIL reset_mid_pend: y_f=%b rise=%b fall=%b rise_cnt=%0d glitch_cnt=%0d, want 0",
               y_f, rise, fall, rise_cnt, glitch_cnt);
    else n_pass++;
    for (int e = 1; e <= Stable + 2; e++) begin
      tick(1'b0, 1'b0, 1'b1);
      if (e == Stable + 1) begin
        n_total++;
        if (y_f !== 1'b0) $display("FAIL reset_release_early: y_f=%b at edge %0d, want 0", y_f, e);
        else n_pass++;
      end
    end
    n_total++;
    if ({y_f, rise} !== 2'b11)
      $display("FAIL reset_release_rise: y_f=%b rise=%b, want 1 1", y_f, rise);
    else n_pass++;
  endtask

  task automatic test_random();
    logic y = 1'b0;
    int   run = 0;
    int   errs = 0;
    logic [2+2*CntW:0] got, exp;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      if (run == 0) begin
        y   = ~y;
        run = int'($urandom_range(1, 7));
      end
      run--;
      tick(($urandom_range(0, 599) == 0), ($urandom_range(0, 49) == 0), y);
      got = {y_f, rise, fall, rise_cnt, glitch_cnt};
      exp = {m_yf[0], m_rise[0], m_fall[0], m_rcnt[CntW-1:0], m_gcnt[CntW-1:0]};
      n_total++;
      if (got !== exp) begin
        if (errs < 10)
          $display("FAIL random cycle %0d: got {y_f,rise,fall,rcnt,gcnt}=%h want %h", i, got, exp);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_short_pulse();
    test_saturation();
    test_clr_coincide();
    test_reset_mid_pend();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
